file_reg: RTL and testbench
===========================

Name: file_reg

Overview:
- Multi-ported register file: 32 entries x 8 bits, one synchronous write port, two independent combinational read ports.
- Serves as the general-purpose operand store of a small datapath.
- Sits between the instruction decode/operand fetch stage (read ports) and the writeback stage (write port).

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 5, width of every address port.
- DEPTH, 32, number of implemented registers; legal range 2..2**ADDR_W.
- WR_BYPASS, 0, when 1 a read of the address being written in the same cycle returns WriteData (write-first); when 0 it returns the stored value (read-old).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous active-low reset; clears the register array.
- WriteEnable  input  1  write strobe, sampled on the rising clk edge.
- WriteAddr  input  ADDR_W  write address.
- WriteData  input  DATA_W  write data.
- ReadAddr1  input  ADDR_W  read port 1 address.
- ReadAddr2  input  ADDR_W  read port 2 address.
- Data1  output  DATA_W  read port 1 data (combinational).
- Data2  output  DATA_W  read port 2 data (combinational).

Behaviour:
- Reset:
  - While rst=0, all DEPTH registers are forced to 0 immediately, independent of clk.
  - Data1 and Data2 therefore read 0 for any address.
  - Writes are ignored while rst=0.
  - Deassertion is asynchronous; the first write takes effect on the first rising edge with rst=1.
- Write:
  - On the rising clk edge with rst=1, WriteEnable=1 and WriteAddr<DEPTH, reg[WriteAddr] <= WriteData.
  - With WriteEnable=0, no register changes.
  - One write per cycle; there is no byte enable and no protected register (register 0 is writable).
- Read:
  - Data1 = reg[ReadAddr1] and Data2 = reg[ReadAddr2], purely combinational, zero-cycle latency.
  - A written value is visible on the read ports immediately after the rising edge that performs the write.
  - Both ports may address the same register simultaneously; both return the same value.
- Same-cycle read/write of one address:
  - WR_BYPASS=0: the read port shows the old value until the edge.
  - WR_BYPASS=1: the read port shows WriteData whenever rst=1, WriteEnable=1 and the addresses match.
- Out of range (only possible when DEPTH<2**ADDR_W):
  - A write to WriteAddr>=DEPTH is dropped.
  - A read from an address >=DEPTH returns 0.
- X handling: an undriven or X read address may yield X on that port only. It must not corrupt stored state.
- Reset asserted mid-write: reset wins; the register ends at 0.

Decomposition:
- Shared package file_reg_pkg:
  - constants FR_DATA_W=8, FR_ADDR_W=5, FR_DEPTH=32;
  - typedefs fr_data_t and fr_addr_t.
- One sub-module is natural: file_reg_rd_port. It is a DEPTH:1 read mux with out-of-range zeroing and the optional bypass compare, instantiated twice.
- Storage array and write decode stay in the top module.

Test Plan:
- Reset: hold rst=0 for 1 ns, then rst=1 -> Data1=Data2=0x00 for ReadAddr1/2 = 0, 1, 31.
- Basic write/read port 1: WriteAddr=0, WriteData=0x07, pulse WriteEnable for one rising edge, then ReadAddr1=0 -> Data1=0x07. Register 1 still reads 0x00.
- Basic write/read port 2: WriteAddr=1, WriteData=0x09, one write edge, ReadAddr2=1 -> Data2=0x09. ReadAddr1=0 still gives Data1=0x07.
- WriteEnable gating: WriteEnable=0 with WriteAddr=0 and WriteData=0xFF across several edges -> Data1 stays 0x07.
- Same-cycle read/write and dual-port read:
  - ReadAddr1=ReadAddr2=5, WriteAddr=5, WriteData=0xA5, WriteEnable=1.
  - Before the edge: Data1=Data2=0x00 (WR_BYPASS=0) or 0xA5 (WR_BYPASS=1).
  - After the edge: both ports read 0xA5.
- Async reset mid-operation:
  - Fill addresses 0..31 with value=addr+1.
  - Verify all 32 entries on both ports.
  - Drop rst between clock edges -> all entries read 0x00 before the next edge.

Source files
------------

// File: rtl/file_reg_pkg.sv
// -----------------------------------------------------------------------------
// file_reg_pkg
//   Shared constants and types for the general-purpose register file.
//   FR_DATA_W / FR_ADDR_W / FR_DEPTH are the default geometry used by the
//   top-level parameters. fr_data_t / fr_addr_t are convenience types for
//   code that works with the default geometry.
// -----------------------------------------------------------------------------
package file_reg_pkg;

  localparam int FR_DATA_W = 8;
  localparam int FR_ADDR_W = 5;
  localparam int FR_DEPTH  = 32;

  typedef logic [FR_DATA_W-1:0] fr_data_t;
  typedef logic [FR_ADDR_W-1:0] fr_addr_t;

endpackage : file_reg_pkg

// File: rtl/file_reg_rd_port.sv
// -----------------------------------------------------------------------------
// file_reg_rd_port
//   One combinational read port of the register file: a DEPTH:1 mux over the
//   storage array, returning zero for addresses at or above DEPTH, with an
//   optional write-first bypass of the write port.
//
// Ports
//   rst          in   asynchronous active-low reset (bypass is off while low)
//   WriteEnable  in   write strobe of the write port
//   WriteAddr    in   write address
//   WriteData    in   write data (bypass source)
//   regFile      in   storage array from the top module
//   ReadAddr     in   read address
//   ReadData     out  read data, combinational
// -----------------------------------------------------------------------------
module file_reg_rd_port
  import file_reg_pkg::*;
#(
  parameter int DATA_W    = FR_DATA_W,
  parameter int ADDR_W    = FR_ADDR_W,
  parameter int DEPTH     = FR_DEPTH,
  parameter int WR_BYPASS = 0
) (
  input  logic              rst,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] regFile [DEPTH],
  input  logic [ADDR_W-1:0] ReadAddr,
  output logic [DATA_W-1:0] ReadData
);

  logic [DATA_W-1:0] storedData;
  logic              bypassHit;

  // Explicit compare-per-entry mux: addresses with no matching entry
  // (ReadAddr >= DEPTH) fall through to the zero default.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    storedData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ReadAddr == ADDR_W'(i)) begin
        storedData = regFile[i];
      end
    end
  end

  // Write-first forwarding. WR_BYPASS is a constant, so with it at 0 this
  // folds away and the port reads the old value until the write edge.
  assign bypassHit = (WR_BYPASS != 0) && rst && WriteEnable &&
                     (WriteAddr == ReadAddr);

  assign ReadData = bypassHit ? WriteData : storedData;

endmodule : file_reg_rd_port

// File: rtl/file_reg.sv
// -----------------------------------------------------------------------------
// file_reg
//   General-purpose operand store: DEPTH registers of DATA_W bits, one
//   synchronous write port (writeback stage) and two independent
//   combinational read ports (operand fetch). Register 0 is an ordinary
//   writable register.
//
// Ports
//   clk          in   rising-edge clock for all state
//   rst          in   asynchronous active-low reset, clears every register
//   WriteEnable  in   write strobe, sampled on the rising clk edge
//   WriteAddr    in   write address (writes at or above DEPTH are dropped)
//   WriteData    in   write data
//   ReadAddr1    in   read port 1 address
//   ReadAddr2    in   read port 2 address
//   Data1        out  read port 1 data, combinational
//   Data2        out  read port 2 data, combinational
//
// Parameters
//   WR_BYPASS    0: same-cycle read of the write address returns the old
//                   value; 1: it returns WriteData (write-first).
// -----------------------------------------------------------------------------
module file_reg
  import file_reg_pkg::*;
#(
  parameter int DATA_W    = FR_DATA_W,
  parameter int ADDR_W    = FR_ADDR_W,
  parameter int DEPTH     = FR_DEPTH,
  parameter int WR_BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteEnable,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2
);

  logic [DATA_W-1:0] regFile [DEPTH];
  logic [DEPTH-1:0]  writeSel;

  // One-hot write decode. Addresses at or above DEPTH select nothing, so
  // such writes are dropped; an X address compares as unknown and selects
  // nothing either, keeping stored state clean.
  always_comb begin
    writeSel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      writeSel[i] = WriteEnable && (WriteAddr == ADDR_W'(i));
    end
  end

  // NOTE: the array is reset because reads must return 0 for every entry
  // straight out of reset; this makes it a flop array rather than a RAM
  // macro, which is intended at this size.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (writeSel[i]) begin
          regFile[i] <= WriteData;
        end
      end
    end
  end

  file_reg_rd_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .WR_BYPASS (WR_BYPASS)
  ) u_rd_port1 (
    .rst         (rst),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .regFile     (regFile),
    .ReadAddr    (ReadAddr1),
    .ReadData    (Data1)
  );

  file_reg_rd_port #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .WR_BYPASS (WR_BYPASS)
  ) u_rd_port2 (
    .rst         (rst),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .regFile     (regFile),
    .ReadAddr    (ReadAddr2),
    .ReadData    (Data2)
  );

endmodule : file_reg

// File: tb/tb_file_reg.sv
// -----------------------------------------------------------------------------
// tb_file_reg
//   Scoreboard bench for file_reg. Stimulus drives inputs shortly after each
//   rising edge and pushes the expected read data into a queue; the monitor
//   pops one entry per falling edge and compares both read ports.
// -----------------------------------------------------------------------------
module tb_file_reg;
  import file_reg_pkg::*;

  localparam int BYPASS = 0;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     WriteEnable = 1'b0;
  fr_addr_t WriteAddr = '0;
  fr_data_t WriteData = '0;
  fr_addr_t ReadAddr1 = '0;
  fr_addr_t ReadAddr2 = '0;
  fr_data_t Data1;
  fr_data_t Data2;

  typedef struct {
    string    name;
    fr_data_t exp1;
    fr_data_t exp2;
  } exp_t;

  exp_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  file_reg #(
    .DATA_W    (FR_DATA_W),
    .ADDR_W    (FR_ADDR_W),
    .DEPTH     (FR_DEPTH),
    .WR_BYPASS (BYPASS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .ReadAddr1   (ReadAddr1),
    .ReadAddr2   (ReadAddr2),
    .Data1       (Data1),
    .Data2       (Data2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input fr_data_t actual,
                       input fr_data_t expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  // Monitor: one scoreboard entry per falling edge, away from the write edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        check({e.name, "/Data1"}, Data1, e.exp1);
        check({e.name, "/Data2"}, Data2, e.exp2);
      end
    end
  end

  // Drive read addresses for one cycle and queue what both ports must show.
  task automatic expectRead(input string name, input fr_addr_t a1,
                            input fr_addr_t a2, input fr_data_t e1,
                            input fr_data_t e2);
    exp_t e;
    @(posedge clk);
    #2;
    ReadAddr1 = a1;
    ReadAddr2 = a2;
    e.name = name;
    e.exp1 = e1;
    e.exp2 = e2;
    expQ.push_back(e);
  endtask

  // One write edge: strobe set after an edge, cleared after the next.
  task automatic writeReg(input fr_addr_t addr, input fr_data_t data);
    @(posedge clk);
    #2;
    WriteEnable = 1'b1;
    WriteAddr   = addr;
    WriteData   = data;
    @(posedge clk);
    #2;
    WriteEnable = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   drain;

    // Reset pulse of 1 ns; starting high gives a real falling edge.
    #1 rst = 1'b0;
    #1 rst = 1'b1;

    expectRead("reset_a0",  5'd0,  5'd0,  8'h00, 8'h00);
    expectRead("reset_a1",  5'd1,  5'd1,  8'h00, 8'h00);
    expectRead("reset_a31", 5'd31, 5'd31, 8'h00, 8'h00);

    // Basic write through port 1; register 1 untouched.
    writeReg(5'd0, 8'h07);
    expectRead("wr0_port1", 5'd0, 5'd1, 8'h07, 8'h00);

    // Basic write through port 2; register 0 unchanged.
    writeReg(5'd1, 8'h09);
    expectRead("wr1_port2", 5'd0, 5'd1, 8'h07, 8'h09);

    // WriteEnable low across several edges must not change register 0.
    @(posedge clk);
    #2;
    WriteAddr = 5'd0;
    WriteData = 8'hFF;
    repeat (3) @(posedge clk);
    expectRead("we_gating", 5'd0, 5'd0, 8'h07, 8'h07);

    // Same-cycle read/write of address 5 on both ports.
    @(posedge clk);
    #2;
    ReadAddr1   = 5'd5;
    ReadAddr2   = 5'd5;
    WriteAddr   = 5'd5;
    WriteData   = 8'hA5;
    WriteEnable = 1'b1;
    e.name = "rw_same_pre";
    e.exp1 = (BYPASS != 0) ? 8'hA5 : 8'h00;
    e.exp2 = (BYPASS != 0) ? 8'hA5 : 8'h00;
    expQ.push_back(e);
    @(posedge clk);
    #2;
    WriteEnable = 1'b0;
    e.name = "rw_same_post";
    e.exp1 = 8'hA5;
    e.exp2 = 8'hA5;
    expQ.push_back(e);

    // Fill every entry with addr+1 and read back on both ports
    // (port 2 walks the array in reverse).
    for (int i = 0; i < FR_DEPTH; i++) begin
      writeReg(fr_addr_t'(i), fr_data_t'(i + 1));
    end
    for (int i = 0; i < FR_DEPTH; i++) begin
      expectRead($sformatf("fill_%0d", i), fr_addr_t'(i),
                 fr_addr_t'(FR_DEPTH - 1 - i), fr_data_t'(i + 1),
                 fr_data_t'(FR_DEPTH - i));
    end

    // Async reset between edges while a write is being presented: entries
    // read 0 before the next edge, and the pending write is ignored.
    @(posedge clk);
    #2;
    WriteEnable = 1'b1;
    WriteAddr   = 5'd3;
    WriteData   = 8'h5A;
    rst         = 1'b0;
    ReadAddr1   = 5'd31;
    ReadAddr2   = 5'd3;
    e.name = "async_rst_now";
    e.exp1 = 8'h00;
    e.exp2 = 8'h00;
    expQ.push_back(e);
    for (int i = 0; i < FR_DEPTH; i += 2) begin
      expectRead($sformatf("in_rst_%0d", i), fr_addr_t'(i),
                 fr_addr_t'(i + 1), 8'h00, 8'h00);
    end
    @(posedge clk);
    #2;
    WriteEnable = 1'b0;
    rst         = 1'b1;
    expectRead("after_rst_3", 5'd3, 5'd0, 8'h00, 8'h00);

    // First edge after release performs a write.
    writeReg(5'd31, 8'hC3);
    expectRead("post_rst_wr", 5'd31, 5'd30, 8'hC3, 8'h00);

    // Let the monitor drain, with a bounded wait.
    drain = 0;
    while (expQ.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (expQ.size() > 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule : tb_file_reg
